branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor table across the five-stage pipeline.
- Holds an in-order queue of in-flight predicted branches from IF and retires them at EX resolution.
- Drives the predictor's update/actual/PC inputs and flushes the pipeline on a mispredict, including the redirect PC.
- Sits between IF (predictor lookup), EX (branch compare) and the PC mux.

Parameters:
DEPTH, 4, in-flight branch queue entries (power of 2, 2..16)
FLUSH_CYC, 2, cycles the recover state holds flush high (1..7)
CNT_W, 16, width of the mispredict statistics counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
if_valid  in  1  IF stage holds a branch this cycle (push request)
if_pc  in  32  PC of that branch
if_pred  in  1  predictor output for if_pc (1 = taken)
if_alt_pc  in  32  PC to use if prediction is wrong (target if pred=0, PC+4 if pred=1)
ex_valid  in  1  EX resolved the oldest in-flight branch this cycle
ex_taken  in  1  actual outcome of that branch
upd_en  out  1  predictor update strobe
upd_pc  out  32  PC for predictor indexing on update
upd_actual  out  1  actual outcome to predictor
flush  out  1  kill IF/ID/EX younger instructions
redirect_pc  out  32  PC to load when flush=1
full  out  1  queue full; IF must stall branch issue
count  out  log2(DEPTH)+1  current queue occupancy
mispred_cnt  out  CNT_W  saturating mispredict count
err  out  1  sticky: ex_valid with empty queue, or push while full

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - queue empty, count=0, full=0.
  - upd_en=0, upd_pc=0, upd_actual=0.
  - flush=0, redirect_pc=0.
  - mispred_cnt=0, err=0.
  - state=RUN.
- Reset mid-recover or mid-update aborts everything, with no pending upd_en.
- Queue: circular buffer of {pc, pred, alt_pc}; wr/rd pointers wrap modulo DEPTH.
  - full = (count==DEPTH).
  - count and full are registered, updated the same edge as the push/pop.
- FSM states are RUN and RECOVER.
- RUN:
  - Push when if_valid && !full. Push while full: entry dropped, err<=1.
  - Pop head when ex_valid && count!=0. Same-cycle push+pop: count unchanged, both take effect.
  - If full and a pop occurs, a same-cycle push is still dropped (full is evaluated pre-edge).
  - ex_valid with empty queue: ignored, err<=1.
  - On pop, next cycle (1-cycle latency): upd_en=1 for exactly one cycle, upd_pc=head.pc, upd_actual=ex_taken.
  - upd_en is never held; it is 0 on cycles without a pop.
  - Mispredict = pop where ex_taken != head.pred. On the same edge:
    - redirect_pc<=head.alt_pc, flush<=1.
    - all queue entries cleared (count<=0, pointers reset); any same-cycle push is discarded as wrong-path.
    - mispred_cnt increments, saturating at all-ones.
    - state<=RECOVER, recover counter<=FLUSH_CYC-1.
  - The update for the mispredicted branch is still issued (upd_en next cycle).
- RECOVER:
  - flush stays 1 and redirect_pc is held stable.
  - if_valid and ex_valid are ignored: no push, no pop, no err.
  - Counter decrements each cycle.
  - When counter==0: flush<=0, state<=RUN.
  - Total flush high time = FLUSH_CYC cycles.
- redirect_pc retains its last value when flush=0.
- err is cleared only by reset.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, count=0, full=0, state RUN.
- Push pc=0x40 pred=1 alt=0x44, then ex_valid taken=1 -> next cycle upd_en=1, upd_pc=0x40, upd_actual=1; flush stays 0; count 1->0.
- Push 0x10(pred0,alt 0x80) and 0x20(pred1); resolve first with taken=1 -> flush=1 for 2 cycles (FLUSH_CYC=2), redirect_pc=0x80, count=0, mispred_cnt=1, upd_pc=0x10 upd_actual=1. Pushes and ex_valid during the flush window are ignored.
- Fill 4 entries, push a 5th -> full=1, entry dropped, err=1. Then simultaneous push+pop -> count remains 3 after pop-only; the push is dropped.
- Simultaneous push+pop at count=2 with correct prediction -> count=2; pointers wrap past DEPTH correctly over 10 consecutive branches, popping in push order.
- Force 2^CNT_W+3 mispredicts (CNT_W=4 build) -> mispred_cnt saturates at 15.
- Assert reset during RECOVER -> flush=0 next cycle, count=0, no upd_en pulse.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Tracks predicted branches from fetch to execute resolution. Each branch the
// IF stage issues is pushed into an in-order circular queue holding its PC,
// its prediction, and the PC to use if the prediction turns out to be wrong.
// When EX resolves the oldest branch, the head is popped, the 2-bit predictor
// is told the real outcome one cycle later, and on a mispredict the pipeline
// is flushed for FLUSH_CYC cycles while the PC mux is redirected.
//
// Parameters
//   DEPTH      in-flight branch queue entries (power of 2, 2..16)
//   FLUSH_CYC  cycles flush stays high after a mispredict (1..7)
//   CNT_W      width of the saturating mispredict counter
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   if_valid     IF holds a branch this cycle (push request)
//   if_pc        PC of that branch
//   if_pred      predicted direction (1 = taken)
//   if_alt_pc    PC to fetch if the prediction is wrong
//   ex_valid     EX resolved the oldest in-flight branch
//   ex_taken     actual direction of that branch
//   upd_en       one-cycle predictor update strobe
//   upd_pc       PC used to index the predictor on update
//   upd_actual   actual outcome handed to the predictor
//   flush        kill younger instructions in IF/ID/EX
//   redirect_pc  PC to load while flush is high (held afterwards)
//   full         queue full, IF must stall branch issue
//   count        queue occupancy
//   mispred_cnt  saturating mispredict count
//   err          sticky protocol error (pop on empty / push while full)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic                     if_pred,
  input  logic [31:0]              if_alt_pc,
  input  logic                     ex_valid,
  input  logic                     ex_taken,
  output logic                     upd_en,
  output logic [31:0]              upd_pc,
  output logic                     upd_actual,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [2:0]       REC_INIT = 3'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // Queue storage. Not reset: occupancy and pointers decide what is valid.
  logic [31:0] q_pc_r   [DEPTH];
  logic        q_pred_r [DEPTH];
  logic [31:0] q_alt_r  [DEPTH];

  state_t           state_r, state_s;
  logic [2:0]       rec_cnt_r, rec_cnt_s;
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [OCC_W-1:0] count_r, count_s;
  logic             full_r, full_s;
  logic             upd_en_r, upd_en_s;
  logic [31:0]      upd_pc_r, upd_pc_s;
  logic             upd_actual_r, upd_actual_s;
  logic             flush_r, flush_s;
  logic [31:0]      redirect_pc_r, redirect_pc_s;
  logic [CNT_W-1:0] mispred_cnt_r, mispred_cnt_s;
  logic             err_r, err_s;

  logic             push_s;
  logic             pop_s;
  logic             mispred_s;
  logic             err_set_s;
  logic [31:0]      head_pc_s;
  logic             head_pred_s;
  logic [31:0]      head_alt_s;

  // Head-of-queue view for the branch EX is resolving.
  always_comb begin
    head_pc_s   = q_pc_r[rd_ptr_r];
    head_pred_s = q_pred_r[rd_ptr_r];
    head_alt_s  = q_alt_r[rd_ptr_r];
  end

  // Qualified queue events; everything is ignored while recovering.
  // full_r is the pre-edge value, so a push while full is dropped even if a
  // pop frees a slot on the same edge.
  always_comb begin
    if (state_r == RUN) begin
      push_s    = if_valid && !full_r;
      pop_s     = ex_valid && (count_r != OCC_ZERO);
      mispred_s = ex_valid && (count_r != OCC_ZERO) && (ex_taken != head_pred_s);
      err_set_s = (if_valid && full_r) || (ex_valid && (count_r == OCC_ZERO));
    end else begin
      push_s    = 1'b0;
      pop_s     = 1'b0;
      mispred_s = 1'b0;
      err_set_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the RUN/RECOVER controller.
  always_comb begin
    state_s       = state_r;
    rec_cnt_s     = rec_cnt_r;
    wr_ptr_s      = wr_ptr_r;
    rd_ptr_s      = rd_ptr_r;
    count_s       = count_r;
    upd_en_s      = 1'b0;
    upd_pc_s      = upd_pc_r;
    upd_actual_s  = upd_actual_r;
    flush_s       = flush_r;
    redirect_pc_s = redirect_pc_r;
    mispred_cnt_s = mispred_cnt_r;
    err_s         = err_r | err_set_s;

    case (state_r)
      RUN: begin
        // The predictor is trained on every resolved branch, mispredicted
        // or not.
        if (pop_s) begin
          upd_en_s     = 1'b1;
          upd_pc_s     = head_pc_s;
          upd_actual_s = ex_taken;
        end else begin
          upd_en_s     = 1'b0;
        end

        if (mispred_s) begin
          // Every younger queued branch (and any same-cycle push) is on the
          // wrong path, so the whole queue is discarded.
          flush_s       = 1'b1;
          redirect_pc_s = head_alt_s;
          wr_ptr_s      = PTR_ZERO;
          rd_ptr_s      = PTR_ZERO;
          count_s       = OCC_ZERO;
          state_s       = RECOVER;
          rec_cnt_s     = REC_INIT;
          if (mispred_cnt_r != CNT_MAX) begin
            mispred_cnt_s = mispred_cnt_r + CNT_ONE;
          end else begin
            mispred_cnt_s = mispred_cnt_r;
          end
        end else begin
          if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
          end else begin
            wr_ptr_s = wr_ptr_r;
          end
          if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
          end else begin
            rd_ptr_s = rd_ptr_r;
          end
          case ({push_s, pop_s})
            2'b10:   count_s = count_r + OCC_ONE;
            2'b01:   count_s = count_r - OCC_ONE;
            default: count_s = count_r;
          endcase
        end
      end

      RECOVER: begin
        // flush was raised on the mispredict edge; holding it through a
        // counter that starts at FLUSH_CYC-1 gives FLUSH_CYC cycles total.
        if (rec_cnt_r == 3'd0) begin
          flush_s = 1'b0;
          state_s = RUN;
        end else begin
          rec_cnt_s = rec_cnt_r - 3'd1;
        end
      end

      default: begin
        state_s = RUN;
        flush_s = 1'b0;
      end
    endcase

    full_s = (count_s == DEPTH_C);
  end

  // Controller, occupancy and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      rec_cnt_r     <= 3'd0;
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      count_r       <= OCC_ZERO;
      full_r        <= 1'b0;
      upd_en_r      <= 1'b0;
      upd_pc_r      <= 32'd0;
      upd_actual_r  <= 1'b0;
      flush_r       <= 1'b0;
      redirect_pc_r <= 32'd0;
      mispred_cnt_r <= {CNT_W{1'b0}};
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      rec_cnt_r     <= rec_cnt_s;
      wr_ptr_r      <= wr_ptr_s;
      rd_ptr_r      <= rd_ptr_s;
      count_r       <= count_s;
      full_r        <= full_s;
      upd_en_r      <= upd_en_s;
      upd_pc_r      <= upd_pc_s;
      upd_actual_r  <= upd_actual_s;
      flush_r       <= flush_s;
      redirect_pc_r <= redirect_pc_s;
      mispred_cnt_r <= mispred_cnt_s;
      err_r         <= err_s;
    end
  end

  // Queue entry write at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      q_pc_r[wr_ptr_r]   <= if_pc;
      q_pred_r[wr_ptr_r] <= if_pred;
      q_alt_r[wr_ptr_r]  <= if_alt_pc;
    end
  end

  assign upd_en      = upd_en_r;
  assign upd_pc      = upd_pc_r;
  assign upd_actual  = upd_actual_r;
  assign flush       = flush_r;
  assign redirect_pc = redirect_pc_r;
  assign full        = full_r;
  assign count       = count_r;
  assign mispred_cnt = mispred_cnt_r;
  assign err         = err_r;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Directed bench for branch_resolve_ctrl (DEPTH=4, FLUSH_CYC=2, CNT_W=4).
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred;
  logic [31:0] if_alt_pc;
  logic        ex_valid;
  logic        ex_taken;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_actual;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        full;
  logic [2:0]  count;
  logic [3:0]  mispred_cnt;
  logic        err;

  int n_cmp;
  int n_err;

  branch_resolve_ctrl #(.DEPTH(4), .FLUSH_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred(if_pred), .if_alt_pc(if_alt_pc),
    .ex_valid(ex_valid), .ex_taken(ex_taken),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_actual(upd_actual),
    .flush(flush), .redirect_pc(redirect_pc),
    .full(full), .count(count), .mispred_cnt(mispred_cnt), .err(err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_in();
    if_valid  = 1'b0;
    if_pc     = 32'd0;
    if_pred   = 1'b0;
    if_alt_pc = 32'd0;
    ex_valid  = 1'b0;
    ex_taken  = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] alt);
    if_valid  = 1'b1;
    if_pc     = pc;
    if_pred   = pred;
    if_alt_pc = alt;
  endtask

  task automatic set_pop(input logic taken);
    ex_valid = 1'b1;
    ex_taken = taken;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();

    // ---- reset / idle state ----
    chk("rst_upd_en",   {31'd0, upd_en},     32'd0);
    chk("rst_upd_pc",   upd_pc,              32'd0);
    chk("rst_upd_act",  {31'd0, upd_actual}, 32'd0);
    chk("rst_flush",    {31'd0, flush},      32'd0);
    chk("rst_redirect", redirect_pc,         32'd0);
    chk("rst_full",     {31'd0, full},       32'd0);
    chk("rst_count",    {29'd0, count},      32'd0);
    chk("rst_mispred",  {28'd0, mispred_cnt}, 32'd0);
    chk("rst_err",      {31'd0, err},        32'd0);

    // ---- correct prediction: push then resolve ----
    set_push(32'h40, 1'b1, 32'h44);
    tick();
    idle_in();
    chk("t2_count1", {29'd0, count}, 32'd1);
    set_pop(1'b1);
    tick();
    idle_in();
    chk("t2_upd_en",  {31'd0, upd_en},     32'd1);
    chk("t2_upd_pc",  upd_pc,              32'h40);
    chk("t2_upd_act", {31'd0, upd_actual}, 32'd1);
    chk("t2_flush",   {31'd0, flush},      32'd0);
    chk("t2_count0",  {29'd0, count},      32'd0);
    tick();
    chk("t2_upd_pulse", {31'd0, upd_en}, 32'd0);

    // ---- mispredict with flush window ----
    set_push(32'h10, 1'b0, 32'h80);
    tick();
    set_push(32'h20, 1'b1, 32'h24);
    tick();
    idle_in();
    chk("t3_count2", {29'd0, count}, 32'd2);
    set_pop(1'b1);
    tick();
    chk("t3_flush1",   {31'd0, flush},       32'd1);
    chk("t3_redirect", redirect_pc,          32'h80);
    chk("t3_count0",   {29'd0, count},       32'd0);
    chk("t3_mispred",  {28'd0, mispred_cnt}, 32'd1);
    chk("t3_upd_en",   {31'd0, upd_en},      32'd1);
    chk("t3_upd_pc",   upd_pc,               32'h10);
    chk("t3_upd_act",  {31'd0, upd_actual},  32'd1);
    // Activity during recovery must be ignored.
    set_push(32'h99, 1'b0, 32'h9C);
    set_pop(1'b0);
    tick();
    chk("t3_flush2",   {31'd0, flush},  32'd1);
    chk("t3_rc_count", {29'd0, count},  32'd0);
    chk("t3_rc_upd",   {31'd0, upd_en}, 32'd0);
    chk("t3_rc_err",   {31'd0, err},    32'd0);
    tick();
    idle_in();
    chk("t3_flush_end", {31'd0, flush}, 32'd0);
    chk("t3_redir_hold", redirect_pc,   32'h80);
    chk("t3_end_count", {29'd0, count}, 32'd0);
    chk("t3_end_err",   {31'd0, err},   32'd0);
    chk("t3_end_upd",   {31'd0, upd_en}, 32'd0);

    // ---- fill, overflow, push+pop while full ----
    for (int i = 0; i < 4; i++) begin
      set_push(32'h100 + 32'(4 * i), 1'b1, 32'h180);
      tick();
    end
    idle_in();
    chk("t4_count4", {29'd0, count}, 32'd4);
    chk("t4_full",   {31'd0, full},  32'd1);
    chk("t4_err0",   {31'd0, err},   32'd0);
    set_push(32'h110, 1'b1, 32'h180);
    tick();
    idle_in();
    chk("t4_ovf_count", {29'd0, count}, 32'd4);
    chk("t4_ovf_full",  {31'd0, full},  32'd1);
    chk("t4_ovf_err",   {31'd0, err},   32'd1);
    set_push(32'h114, 1'b1, 32'h180);
    set_pop(1'b1);
    tick();
    idle_in();
    chk("t4_pp_count", {29'd0, count}, 32'd3);
    chk("t4_pp_full",  {31'd0, full},  32'd0);
    chk("t4_pp_updpc", upd_pc,         32'h100);
    chk("t4_pp_flush", {31'd0, flush}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      set_pop(1'b1);
      tick();
      idle_in();
      chk("t4_drain_pc", upd_pc, 32'h100 + 32'(4 * i));
    end
    chk("t4_drain_count", {29'd0, count}, 32'd0);

    // ---- steady push+pop at count=2, pointers wrap ----
    set_push(32'h200, 1'b0, 32'h300);
    tick();
    set_push(32'h204, 1'b1, 32'h301);
    tick();
    idle_in();
    for (int i = 2; i < 10; i++) begin
      set_push(32'h200 + 32'(4 * i), i[0], 32'h300 + 32'(i));
      set_pop((i - 2) % 2 == 1);
      tick();
      idle_in();
      chk("t5_count", {29'd0, count}, 32'd2);
      chk("t5_updpc", upd_pc, 32'h200 + 32'(4 * (i - 2)));
      chk("t5_flush", {31'd0, flush}, 32'd0);
    end
    set_pop(1'b0);
    tick();
    idle_in();
    chk("t5_tail8", upd_pc, 32'h220);
    set_pop(1'b1);
    tick();
    idle_in();
    chk("t5_tail9",   upd_pc, 32'h224);
    chk("t5_count0",  {29'd0, count}, 32'd0);
    chk("t5_mispred", {28'd0, mispred_cnt}, 32'd1);

    // ---- saturate the mispredict counter (1 so far + 18 more = 19) ----
    for (int i = 0; i < 18; i++) begin
      set_push(32'h500, 1'b0, 32'h600 + 32'(i));
      tick();
      idle_in();
      set_pop(1'b1);
      tick();
      idle_in();
      chk("t6_mispred", {28'd0, mispred_cnt}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
      chk("t6_redirect", redirect_pc, 32'h600 + 32'(i));
      tick();
      tick();
    end
    chk("t6_sat", {28'd0, mispred_cnt}, 32'd15);

    // ---- reset during recovery ----
    set_push(32'h700, 1'b1, 32'h704);
    tick();
    idle_in();
    set_pop(1'b0);
    tick();
    idle_in();
    chk("t7_flush_pre", {31'd0, flush},  32'd1);
    chk("t7_upd_pre",   {31'd0, upd_en}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_flush",   {31'd0, flush},       32'd0);
    chk("t7_count",   {29'd0, count},       32'd0);
    chk("t7_upd_en",  {31'd0, upd_en},      32'd0);
    chk("t7_err",     {31'd0, err},         32'd0);
    chk("t7_mispred", {28'd0, mispred_cnt}, 32'd0);
    chk("t7_redirect", redirect_pc,         32'd0);
    tick();
    chk("t7_flush_post", {31'd0, flush},  32'd0);
    chk("t7_upd_post",   {31'd0, upd_en}, 32'd0);

    // ---- resolve with an empty queue ----
    set_pop(1'b1);
    tick();
    idle_in();
    chk("t8_err",   {31'd0, err},    32'd1);
    chk("t8_upd",   {31'd0, upd_en}, 32'd0);
    chk("t8_count", {29'd0, count},  32'd0);
    tick();
    chk("t8_err_sticky", {31'd0, err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
